// File: rtl/omap_biu_pkg.sv
// rtl/omap_biu_pkg.sv - shared constants and state encoding for omap_biu
package omap_biu_pkg;
   localparam int AW_DEF   = 16;
   localparam int PACK_DEF = 8;
   // quan_merge byte lane within the merged-pixel input word
   localparam int QM_LSB   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAST = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/omap_pack_reg.sv
// rtl/omap_pack_reg.sv - byte packer: gathers PACK bytes plus mask into one SRAM word
module omap_pack_reg
   import omap_biu_pkg::*;
#(
   parameter int PACK = PACK_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic              i_last,
   input  logic [7:0]        i_byte,
   output logic              o_flush,
   output logic [8*PACK-1:0] o_data,
   output logic [PACK-1:0]   o_mask
);
   localparam int IW = $clog2(PACK);

   logic [8*PACK-1:0] r_data;
   logic [PACK-1:0]   r_mask;
   logic [IW-1:0]     r_cnt;
   logic              w_full;

   // o_data/o_mask already include the byte being pushed, so a flush hands over the complete word
   always_comb begin
      o_data = r_data;
      o_mask = r_mask;
      if (i_push) begin
         o_data[{r_cnt, 3'b000} +: 8] = i_byte;
         o_mask[r_cnt]                = 1'b1;
      end
   end

   assign w_full  = (r_cnt == IW'(PACK - 1));
   assign o_flush = i_push & (w_full | i_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_mask <= '0;
         r_cnt  <= '0;
      end else if (i_clr || o_flush) begin
         r_data <= '0;
         r_mask <= '0;
         r_cnt  <= '0;
      end else if (i_push) begin
         r_data <= o_data;
         r_mask <= o_mask;
         r_cnt  <= r_cnt + IW'(1);
      end
   end
endmodule

// File: rtl/omap_biu.sv
// rtl/omap_biu.sv - output-map BIU: packs quan_merge bytes and writes them to the output-map SRAM
module omap_biu
   import omap_biu_pkg::*;
#(
   parameter int AW   = AW_DEF,
   parameter int PACK = PACK_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic [AW-1:0]     cfg_base_addr,
   input  logic [15:0]       cfg_pix_num,
   input  logic [31:0]       map_merger2omap_biu_data,
   input  logic              map_merger2omap_biu_vld,
   output logic              map_merger2omap_biu_rdy,
   output logic              omap_sram_req,
   input  logic              omap_sram_gnt,
   output logic [AW-1:0]     omap_sram_addr,
   output logic [8*PACK-1:0] omap_sram_wdata,
   output logic [PACK-1:0]   omap_sram_wmask,
   output logic              omap_biu_busy,
   output logic              omap_biu_done
);
   state_t            r_state, w_state_nxt;
   logic [15:0]       r_pix_num, r_pix_cnt;
   logic [AW-1:0]     r_addr;
   logic              r_pend;
   logic [8*PACK-1:0] r_wdata;
   logic [PACK-1:0]   r_wmask;

   logic              w_start, w_acc, w_last, w_wr, w_flush;
   logic [8*PACK-1:0] w_pack_data;
   logic [PACK-1:0]   w_pack_mask;
   logic              w_unused;

   assign w_unused = ^{map_merger2omap_biu_data[31:QM_LSB+8], map_merger2omap_biu_data[QM_LSB-1:0]};

   assign w_start = (r_state == ST_IDLE) & cfg_start;
   assign w_wr    = r_pend & omap_sram_gnt;
   // a grant this cycle frees the pending slot, so a new word may complete alongside it
   assign map_merger2omap_biu_rdy = (r_state == ST_RUN) & (!r_pend | omap_sram_gnt);
   assign w_acc   = map_merger2omap_biu_vld & map_merger2omap_biu_rdy;
   assign w_last  = ((r_pix_cnt + 16'd1) == r_pix_num);

   omap_pack_reg #(.PACK(PACK)) u_pack (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_start),
      .i_push  (w_acc),
      .i_last  (w_last),
      .i_byte  (map_merger2omap_biu_data[QM_LSB +: 8]),
      .o_flush (w_flush),
      .o_data  (w_pack_data),
      .o_mask  (w_pack_mask)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (cfg_start) w_state_nxt = (cfg_pix_num == 16'd0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (w_acc && w_last) w_state_nxt = ST_LAST;
         ST_LAST: if (w_wr) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pix_num <= '0;
         r_pix_cnt <= '0;
         r_addr    <= '0;
         r_pend    <= 1'b0;
         r_wdata   <= '0;
         r_wmask   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_addr    <= cfg_base_addr;
            r_pix_num <= cfg_pix_num;
            r_pix_cnt <= '0;
         end else begin
            if (w_wr)  r_addr    <= r_addr + AW'(1);
            if (w_acc) r_pix_cnt <= r_pix_cnt + 16'd1;
         end
         if (w_flush) begin
            r_pend  <= 1'b1;
            r_wdata <= w_pack_data;
            r_wmask <= w_pack_mask;
         end else if (w_wr) begin
            r_pend  <= 1'b0;
         end
      end
   end

   assign omap_sram_req   = r_pend;
   assign omap_sram_addr  = r_addr;
   assign omap_sram_wdata = r_wdata;
   assign omap_sram_wmask = r_wmask;
   assign omap_biu_busy   = (r_state != ST_IDLE);
   assign omap_biu_done   = (r_state == ST_DONE);
endmodule

// File: tb/tb_omap_biu.sv
// tb/tb_omap_biu.sv - directed self-checking bench for omap_biu
module tb_omap_biu;
   localparam int AW   = 16;
   localparam int PACK = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_start = 1'b0;
   logic [AW-1:0]     cfg_base_addr = '0;
   logic [15:0]       cfg_pix_num = '0;
   logic [31:0]       map_merger2omap_biu_data = '0;
   logic              map_merger2omap_biu_vld = 1'b0;
   logic              map_merger2omap_biu_rdy;
   logic              omap_sram_req;
   logic              omap_sram_gnt = 1'b1;
   logic [AW-1:0]     omap_sram_addr;
   logic [8*PACK-1:0] omap_sram_wdata;
   logic [PACK-1:0]   omap_sram_wmask;
   logic              omap_biu_busy;
   logic              omap_biu_done;

   omap_biu #(.AW(AW), .PACK(PACK)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .cfg_start                (cfg_start),
      .cfg_base_addr            (cfg_base_addr),
      .cfg_pix_num              (cfg_pix_num),
      .map_merger2omap_biu_data (map_merger2omap_biu_data),
      .map_merger2omap_biu_vld  (map_merger2omap_biu_vld),
      .map_merger2omap_biu_rdy  (map_merger2omap_biu_rdy),
      .omap_sram_req            (omap_sram_req),
      .omap_sram_gnt            (omap_sram_gnt),
      .omap_sram_addr           (omap_sram_addr),
      .omap_sram_wdata          (omap_sram_wdata),
      .omap_sram_wmask          (omap_sram_wmask),
      .omap_biu_busy            (omap_biu_busy),
      .omap_biu_done            (omap_biu_done)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_done = 0;
   int done_cyc = 0;
   logic [AW-1:0] wr_addr[$];
   logic [63:0]   wr_data[$];
   logic [7:0]    wr_mask[$];
   int            wr_cyc[$];
   int            acc_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (omap_sram_req && omap_sram_gnt) begin
         wr_addr.push_back(omap_sram_addr);
         wr_data.push_back(omap_sram_wdata);
         wr_mask.push_back(omap_sram_wmask);
         wr_cyc.push_back(cyc);
      end
      if (omap_biu_done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (map_merger2omap_biu_vld && map_merger2omap_biu_rdy) acc_cyc.push_back(cyc);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [15:0] a,
                           input logic [63:0] d, input logic [7:0] m);
      if (idx >= wr_addr.size()) begin
         check({tag, "_missing"}, 64'(wr_addr.size()), 64'(idx + 1));
      end else begin
         check({tag, "_addr"}, 64'(wr_addr[idx]), 64'(a));
         check({tag, "_data"}, wr_data[idx], d);
         check({tag, "_mask"}, 64'(wr_mask[idx]), 64'(m));
      end
   endtask

   task automatic do_start(input logic [15:0] base, input logic [15:0] num);
      cfg_base_addr = base;
      cfg_pix_num   = num;
      cfg_start     = 1'b1;
      @(posedge clk); #1;
      cfg_start     = 1'b0;
   endtask

   task automatic push_pix(input logic [31:0] w);
      int t = 0;
      map_merger2omap_biu_vld  = 1'b1;
      map_merger2omap_biu_data = w;
      @(negedge clk);
      while (!map_merger2omap_biu_rdy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!map_merger2omap_biu_rdy) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      map_merger2omap_biu_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      @(negedge clk);
      while (!omap_biu_done && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!omap_biu_done) check({tag, "_done_timeout"}, 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int b, a, nd;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_rdy",   64'(map_merger2omap_biu_rdy), 0);
      check("rst_req",   64'(omap_sram_req), 0);
      check("rst_addr",  64'(omap_sram_addr), 0);
      check("rst_wdata", omap_sram_wdata, 0);
      check("rst_wmask", 64'(omap_sram_wmask), 0);
      check("rst_busy",  64'(omap_biu_busy), 0);
      check("rst_done",  64'(omap_biu_done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic map, full words, one pixel per cycle
      b = wr_addr.size(); a = acc_cyc.size();
      do_start(16'h0100, 16'd16);
      for (int i = 0; i < 16; i++) push_pix({8'hEE, 8'(i + 1), 8'h33, 8'h44});
      wait_done("basic");
      @(negedge clk);
      check("basic_busy_low", 64'(omap_biu_busy), 0);
      @(posedge clk); #1;
      check("basic_nwr", 64'(wr_addr.size() - b), 2);
      check_wr("basic_w0", b,     16'h0100, 64'h0807060504030201, 8'hFF);
      check_wr("basic_w1", b + 1, 16'h0101, 64'h100F0E0D0C0B0A09, 8'hFF);
      check("basic_nacc", 64'(acc_cyc.size() - a), 16);
      if (acc_cyc.size() >= a + 16) check("basic_rate", 64'(acc_cyc[a + 15] - acc_cyc[a]), 15);
      if (wr_cyc.size() >= b + 2) check("basic_done_lat", 64'(done_cyc - wr_cyc[b + 1]), 1);

      // partial final word
      b = wr_addr.size(); a = acc_cyc.size();
      do_start(16'h0210, 16'd11);
      for (int i = 0; i < 11; i++) push_pix({8'h00, 8'(8'hA0 + i), 16'h0000});
      wait_done("part");
      check_wr("part_w0", b,     16'h0210, 64'hA7A6A5A4A3A2A1A0, 8'hFF);
      check_wr("part_w1", b + 1, 16'h0211, 64'h0000000000AAA9A8, 8'h07);
      map_merger2omap_biu_vld = 1'b1;
      @(negedge clk);
      check("part_rdy_after", 64'(map_merger2omap_biu_rdy), 0);
      @(posedge clk); #1;
      map_merger2omap_biu_vld = 1'b0;
      check("part_nacc", 64'(acc_cyc.size() - a), 11);

      // backpressure: grant withheld at the first request
      b = wr_addr.size(); a = acc_cyc.size();
      omap_sram_gnt = 1'b0;
      do_start(16'h0300, 16'd24);
      fork
         begin
            for (int i = 0; i < 24; i++) push_pix({8'h00, 8'(8'h30 + i), 16'h0000});
         end
         begin
            int t = 0;
            @(negedge clk);
            while (!omap_sram_req && t < 100) begin
               @(negedge clk);
               t++;
            end
            repeat (20) @(negedge clk);
            check("bp_acc_held", 64'(acc_cyc.size() - a), 8);
            check("bp_rdy_low",  64'(map_merger2omap_biu_rdy), 0);
            check("bp_req_held", 64'(omap_sram_req), 1);
            check("bp_addr",     64'(omap_sram_addr), 64'h0300);
            @(posedge clk); #1;
            omap_sram_gnt = 1'b1;
         end
      join
      wait_done("bp");
      check("bp_nacc", 64'(acc_cyc.size() - a), 24);
      check_wr("bp_w0", b,     16'h0300, 64'h3736353433323130, 8'hFF);
      check_wr("bp_w1", b + 1, 16'h0301, 64'h3F3E3D3C3B3A3938, 8'hFF);
      check_wr("bp_w2", b + 2, 16'h0302, 64'h4746454443424140, 8'hFF);
      if (acc_cyc.size() >= a + 24) check("bp_rate", 64'(acc_cyc[a + 23] - acc_cyc[a + 8]), 15);

      // zero-length map
      b = wr_addr.size(); nd = n_done;
      do_start(16'h0400, 16'd0);
      @(negedge clk);
      check("zero_done", 64'(omap_biu_done), 1);
      @(negedge clk);
      check("zero_busy_low", 64'(omap_biu_busy), 0);
      check("zero_nwr", 64'(wr_addr.size() - b), 0);
      check("zero_ndone", 64'(n_done - nd), 1);
      @(posedge clk); #1;

      // start while busy is ignored
      b = wr_addr.size(); a = acc_cyc.size(); nd = n_done;
      do_start(16'h0500, 16'd16);
      for (int i = 0; i < 3; i++) push_pix({8'h00, 8'(8'h51 + i), 16'h0000});
      cfg_base_addr = 16'h7777;
      cfg_pix_num   = 16'd2;
      cfg_start     = 1'b1;
      @(posedge clk); #1;
      cfg_start     = 1'b0;
      for (int i = 3; i < 16; i++) push_pix({8'h00, 8'(8'h51 + i), 16'h0000});
      wait_done("restart");
      check("restart_nwr", 64'(wr_addr.size() - b), 2);
      check("restart_ndone", 64'(n_done - nd), 1);
      check_wr("restart_w0", b,     16'h0500, 64'h5857565554535251, 8'hFF);
      check_wr("restart_w1", b + 1, 16'h0501, 64'h605F5E5D5C5B5A59, 8'hFF);

      // address wrap and byte-lane select
      b = wr_addr.size();
      do_start(16'hFFFF, 16'd16);
      for (int i = 0; i < 16; i++) push_pix(32'h55AA33CC);
      wait_done("wrap");
      check_wr("wrap_w0", b,     16'hFFFF, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      check_wr("wrap_w1", b + 1, 16'h0000, 64'hAAAAAAAAAAAAAAAA, 8'hFF);

      // mid-map reset
      b = wr_addr.size(); nd = n_done;
      do_start(16'h0600, 16'd16);
      for (int i = 0; i < 5; i++) push_pix({8'h00, 8'(8'h61 + i), 16'h0000});
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_rdy",   64'(map_merger2omap_biu_rdy), 0);
      check("mrst_req",   64'(omap_sram_req), 0);
      check("mrst_addr",  64'(omap_sram_addr), 0);
      check("mrst_wdata", omap_sram_wdata, 0);
      check("mrst_wmask", 64'(omap_sram_wmask), 0);
      check("mrst_busy",  64'(omap_biu_busy), 0);
      check("mrst_done",  64'(omap_biu_done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_start(16'h0200, 16'd8);
      for (int i = 0; i < 8; i++) push_pix({8'h00, 8'(8'h11 + i), 16'h0000});
      wait_done("mrst");
      check("mrst_nwr", 64'(wr_addr.size() - b), 1);
      check("mrst_ndone", 64'(n_done - nd), 1);
      check_wr("mrst_w0", b, 16'h0200, 64'h1817161514131211, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
